// File: rtl/cselector_n_mmu.sv
// cselector_n_mmu: clocked N-way request selector for the MMU handshake fabric.
// Queues up to DEPTH requests ({select, payload}). Each request is steered to the
// consumer(s) named by its select vector. A select that cannot be served is consumed
// and dropped, and that drop is flagged on o_err one cycle later.
// Optional feature macro: CSELECTOR_MULTICAST_EN. When it is defined, any non-zero
// select forks to several consumers. When it is undefined, the select must be
// strictly one-hot.
module cselector_n_mmu #(
    parameter int NUM_PORTS = 3,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_drive,
    output logic                         o_free,
    input  logic [NUM_PORTS-1:0]         i_select,
    input  logic [WIDTH-1:0]             i_data,
    output logic [NUM_PORTS-1:0]         o_driveNext,
    input  logic [NUM_PORTS-1:0]         i_freeNext,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_err,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = NUM_PORTS + WIDTH;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]        CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
    localparam logic [NUM_PORTS-1:0] SEL_ZERO  = {NUM_PORTS{1'b0}};
    localparam logic [NUM_PORTS-1:0] SEL_ONE   = NUM_PORTS'(1);

    // Select validation: a fork needs any bit set; a unicast needs exactly one bit set.
    function automatic logic selValid(input logic [NUM_PORTS-1:0] sel);
`ifdef CSELECTOR_MULTICAST_EN
        return (sel != SEL_ZERO);
`else
        return (sel != SEL_ZERO) && ((sel & (sel - SEL_ONE)) == SEL_ZERO);
`endif
    endfunction

    // Storage and state
    logic [EW-1:0]        memR [DEPTH];
    logic [PW-1:0]        rdPtrR;
    logic [PW-1:0]        wrPtrR;
    logic [CW-1:0]        countR;
    logic [WIDTH-1:0]     holdR;
    logic                 errR;
`ifdef CSELECTOR_MULTICAST_EN
    logic [NUM_PORTS-1:0] doneR;
`endif

    // Datapath/control nets
    logic                 emptyS;
    logic                 fullS;
    logic [EW-1:0]        headS;
    logic [NUM_PORTS-1:0] headSelS;
    logic [WIDTH-1:0]     headDataS;
    logic [NUM_PORTS-1:0] driveS;
    logic [NUM_PORTS-1:0] firedS;
    logic                 acceptS;
    logic                 pushS;
    logic                 dropS;
    logic                 popS;

    // Occupancy flags and head decode, all taken from registered state.
    always_comb begin
        emptyS    = (countR == CNT_ZERO);
        fullS     = (countR == DEPTH_C);
        headS     = memR[rdPtrR];
        headSelS  = headS[EW-1:WIDTH];
        headDataS = headS[WIDTH-1:0];
    end

    // Per-consumer valid: only selected consumers that are not already served.
    always_comb begin
        driveS = SEL_ZERO;
        if (emptyS) begin
            driveS = SEL_ZERO;
        end else begin
`ifdef CSELECTOR_MULTICAST_EN
            driveS = headSelS & ~doneR;
`else
            driveS = headSelS;
`endif
        end
        firedS = driveS & i_freeNext;
    end

    // Accept/push/drop on the upstream side, pop once every selected consumer has fired.
    always_comb begin
        acceptS = i_drive & ~fullS;
        pushS   = 1'b0;
        dropS   = 1'b0;
        if (acceptS) begin
            pushS = selValid(i_select);
            dropS = ~selValid(i_select);
        end else begin
            pushS = 1'b0;
            dropS = 1'b0;
        end
        popS = 1'b0;
        if (emptyS) begin
            popS = 1'b0;
        end else begin
`ifdef CSELECTOR_MULTICAST_EN
            popS = (((doneR | firedS) & headSelS) == headSelS);
`else
            popS = (firedS != SEL_ZERO);
`endif
        end
    end

    // Entry storage write; contents are only observed when the count covers them.
    always_ff @(posedge clk) begin
        if (pushS) begin
            memR[wrPtrR] <= {i_select, i_data};
        end
    end

    // Write/read pointers, wrapping modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrR <= {PW{1'b0}};
            rdPtrR <= {PW{1'b0}};
        end else begin
            wrPtrR <= pushS ? (wrPtrR + PTR_ONE) : wrPtrR;
            rdPtrR <= popS  ? (rdPtrR + PTR_ONE) : rdPtrR;
        end
    end

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countR <= CNT_ZERO;
        end else begin
            case ({pushS, popS})
                2'b10:   countR <= countR + CNT_ONE;
                2'b01:   countR <= countR - CNT_ONE;
                default: countR <= countR;
            endcase
        end
    end

    // Remember the last presented payload so o_data holds it while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdR <= {WIDTH{1'b0}};
        end else if (!emptyS) begin
            holdR <= headDataS;
        end else begin
            holdR <= holdR;
        end
    end

    // One-cycle error pulse for a dropped (invalid) select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errR <= 1'b0;
        end else begin
            errR <= dropS;
        end
    end

`ifdef CSELECTOR_MULTICAST_EN
    // Track which consumers of the head entry have already fired; clear on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            doneR <= SEL_ZERO;
        end else if (popS) begin
            doneR <= SEL_ZERO;
        end else begin
            doneR <= doneR | firedS;
        end
    end
`endif

    // Output mapping
    assign o_free      = ~fullS;
    assign o_driveNext = driveS;
    assign o_data      = emptyS ? holdR : headDataS;
    assign o_err       = errR;
    assign o_count     = countR;

endmodule
